// File: rtl/uart_tx_arb.sv
// Round-robin share of one uart_tx FIFO-read port among NUM_REQ latency-1 byte FIFOs; grant held per burst.
// Grant 1 cycle after IDLE sees a source; read forwarded combinationally, byte out next cycle; uart_tx paces via rd_en/tx_done.
module uart_tx_arb #(
  parameter int unsigned D_WIDTH   = 8,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BURST_MAX = 16
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic [NUM_REQ-1:0]           req_empty,
  input  logic [NUM_REQ*D_WIDTH-1:0]   req_rd_data,
  input  logic [NUM_REQ-1:0]           req_mask,
  output logic [NUM_REQ-1:0]           req_rd_en,
  input  logic                         uart_rd_en,
  input  logic                         uart_tx_done,
  output logic                         uart_empty,
  output logic [D_WIDTH-1:0]           uart_tx_data,
  output logic [2:0]                   grant_id,
  output logic                         busy
);

  typedef enum logic [1:0] {IDLE, ARM, SEND} state_t;

  state_t               state_q, state_d;
  logic [2:0]           grant_q, grant_d;
  logic [2:0]           last_q, last_d;
  logic [7:0]           cnt_q, cnt_d, cnt_inc;
  logic                 hold_vld_q, hold_vld_d;
  logic                 busy_q, busy_d;
  logic [D_WIDTH-1:0]   hold_q, hold_d;
  logic [D_WIDTH-1:0]   src_data;
  logic                 src_empty, src_mask, rd_fwd, found;
  logic [NUM_REQ-1:0]   elig;
  logic [2:0]           pick;

  always_comb begin : src_sel
    src_empty = 1'b1;
    src_mask  = 1'b0;
    src_data  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_q == 3'(i)) begin
        src_empty = req_empty[i];
        src_mask  = req_mask[i];
        src_data  = req_rd_data[i*D_WIDTH +: D_WIDTH];
      end
    end
  end

  // First eligible requester scanning circularly from last_grant+1.
  always_comb begin : rr_pick
    elig  = req_mask & ~req_empty;
    found = 1'b0;
    pick  = last_q;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      for (int j = 0; j < int'(NUM_REQ); j++) begin
        if (!found && elig[j] && (j == (int'(last_q) + k) % int'(NUM_REQ))) begin
          found = 1'b1;
          pick  = 3'(j);
        end
      end
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 8'd1;
    rd_fwd  = (state_q == ARM) && uart_rd_en && !src_empty;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = ARM;
        end
      end
      ARM: begin
        if (rd_fwd) begin
          state_d = SEND;
        end else if (src_empty || !src_mask) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      SEND: begin
        if (uart_tx_done) begin
          cnt_d = cnt_inc;
          if ((cnt_inc == 8'(BURST_MAX)) || src_empty || !src_mask) begin
            state_d = IDLE;
            last_d  = grant_q;
          end else begin
            state_d = ARM;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    hold_vld_d = rd_fwd;
    // The byte lands one cycle after the read; freeze it for the rest of the frame.
    hold_d     = hold_vld_q ? src_data : hold_q;
    busy_d     = (state_d != IDLE);
  end

  always_comb begin : outs
    uart_empty = (state_q == ARM) ? src_empty : 1'b1;
    req_rd_en  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_rd_en[i] = rd_fwd && (grant_q == 3'(i));
    end
    uart_tx_data = hold_vld_q ? src_data : hold_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= 3'(NUM_REQ - 1);
      cnt_q      <= '0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: latency-1 source FIFO models plus a scripted uart_tx reader.
module tb_uart_tx_arb;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [3:0]  req_empty;
  logic [31:0] req_rd_data;
  logic [3:0]  req_mask = 4'hF;
  logic [3:0]  req_rd_en;
  logic        uart_rd_en = 1'b0;
  logic        uart_tx_done = 1'b0;
  logic        uart_empty;
  logic [7:0]  uart_tx_data;
  logic [2:0]  grant_id;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] fmem [4][64];
  int         wp [4] = '{0, 0, 0, 0};
  int         rp [4] = '{0, 0, 0, 0};
  logic [7:0] rdq [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic       scramble = 1'b0;

  uart_tx_arb #(.D_WIDTH(8), .NUM_REQ(4), .BURST_MAX(16)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .req_empty    (req_empty),
    .req_rd_data  (req_rd_data),
    .req_mask     (req_mask),
    .req_rd_en    (req_rd_en),
    .uart_rd_en   (uart_rd_en),
    .uart_tx_done (uart_tx_done),
    .uart_empty   (uart_empty),
    .uart_tx_data (uart_tx_data),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 sys_clk = ~sys_clk;

  always_comb begin
    req_empty   = '1;
    req_rd_data = '0;
    for (int i = 0; i < 4; i++) begin
      req_empty[i]          = (wp[i] == rp[i]);
      req_rd_data[i*8 +: 8] = rdq[i];
    end
  end

  // Source FIFOs: data appears the cycle after the read strobe.
  always @(posedge sys_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (req_rd_en[i]) begin
        rdq[i] <= fmem[i][rp[i] % 64];
        rp[i]  <= rp[i] + 1;
      end else if (scramble) begin
        rdq[i] <= rdq[i] + 8'h11;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input int id, input logic [7:0] b);
    fmem[id][wp[id] % 64] = b;
    wp[id] = wp[id] + 1;
  endtask

  task automatic wait_ready(input int exp_wait);
    int w;
    w = 0;
    while (uart_empty && w < 40) begin
      tick();
      w++;
    end
    chk("ready_wait", w, exp_wait);
  endtask

  task automatic serve(input int id, input logic [7:0] b, input int exp_wait);
    wait_ready(exp_wait);
    chk("grant_id", {29'd0, grant_id}, id);
    uart_rd_en = 1'b1;
    #1;
    chk("req_rd_en", {28'd0, req_rd_en}, 32'(1 << id));
    tick();
    uart_rd_en = 1'b0;
    #1;
    chk("tx_data_live", {24'd0, uart_tx_data}, {24'd0, b});
    chk("send_empty", {31'd0, uart_empty}, 1);
    tick();
    tick();
    chk("tx_data_hold", {24'd0, uart_tx_data}, {24'd0, b});
    uart_tx_done = 1'b1;
    tick();
    uart_tx_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int id, base, len;

    // Reset state
    tick();
    tick();
    chk("rst_uart_empty", {31'd0, uart_empty}, 1);
    chk("rst_req_rd_en", {28'd0, req_rd_en}, 0);
    chk("rst_tx_data", {24'd0, uart_tx_data}, 0);
    chk("rst_grant_id", {29'd0, grant_id}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    #2 sys_rst_n = 1'b1;
    tick();
    chk("idle_no_src", {31'd0, busy}, 0);

    // Two sources with 20 bytes each: 0(16), 2(16), 0(4), 2(4)
    for (int r = 0; r < 20; r++) begin
      push(0, 8'(8'h10 + r));
      push(2, 8'(8'h80 + r));
    end
    for (int b = 0; b < 4; b++) begin
      id   = (b % 2 == 0) ? 0 : 2;
      base = (b < 2) ? 0 : 16;
      len  = (b < 2) ? 16 : 4;
      for (int n = 0; n < len; n++) begin
        serve(id, 8'(((id == 0) ? 8'h10 : 8'h80) + base + n), (n == 0) ? 1 : 0);
      end
    end
    chk("bursts_done_busy", {31'd0, busy}, 0);

    // Single source, three bytes
    push(0, 8'hA5);
    push(0, 8'h3C);
    push(0, 8'hFF);
    serve(0, 8'hA5, 1);
    serve(0, 8'h3C, 0);
    serve(0, 8'hFF, 0);
    chk("t1_busy_drop", {31'd0, busy}, 0);
    tick();
    chk("t1_idle_busy", {31'd0, busy}, 0);
    chk("t1_idle_empty", {31'd0, uart_empty}, 1);

    // Masked requester 1 skipped, then granted once unmasked
    req_mask = 4'b1101;
    push(1, 8'h11);
    push(1, 8'h12);
    push(3, 8'h31);
    push(3, 8'h32);
    serve(3, 8'h31, 1);
    req_mask = 4'hF;
    serve(3, 8'h32, 0);
    serve(1, 8'h11, 1);
    serve(1, 8'h12, 0);

    // Source data churns during SEND
    scramble = 1'b1;
    push(2, 8'h5A);
    serve(2, 8'h5A, 1);
    scramble = 1'b0;

    // Async reset mid-frame with grant 2
    push(2, 8'h77);
    push(2, 8'h78);
    wait_ready(1);
    chk("t5_grant", {29'd0, grant_id}, 2);
    uart_rd_en = 1'b1;
    tick();
    uart_rd_en = 1'b0;
    chk("t5_in_send", {31'd0, busy}, 1);
    sys_rst_n = 1'b0;
    #1;
    chk("t5_rst_empty", {31'd0, uart_empty}, 1);
    chk("t5_rst_rd_en", {28'd0, req_rd_en}, 0);
    chk("t5_rst_busy", {31'd0, busy}, 0);
    chk("t5_rst_grant", {29'd0, grant_id}, 0);
    chk("t5_rst_data", {24'd0, uart_tx_data}, 0);
    push(0, 8'h01);
    sys_rst_n = 1'b1;
    serve(0, 8'h01, 1);
    serve(2, 8'h78, 1);

    // Spurious strobes in IDLE, ARM and SEND
    uart_tx_done = 1'b1;
    uart_rd_en   = 1'b1;
    #1;
    chk("t6_idle_rd_en", {28'd0, req_rd_en}, 0);
    tick();
    uart_tx_done = 1'b0;
    uart_rd_en   = 1'b0;
    chk("t6_idle_busy", {31'd0, busy}, 0);
    chk("t6_idle_empty", {31'd0, uart_empty}, 1);
    push(1, 8'h21);
    push(1, 8'h22);
    wait_ready(1);
    chk("t6_grant", {29'd0, grant_id}, 1);
    uart_tx_done = 1'b1;
    tick();
    uart_tx_done = 1'b0;
    chk("t6_arm_kept", {31'd0, uart_empty}, 0);
    chk("t6_arm_busy", {31'd0, busy}, 1);
    uart_rd_en = 1'b1;
    #1;
    chk("t6_rd_en", {28'd0, req_rd_en}, 32'h2);
    tick();
    uart_rd_en = 1'b0;
    chk("t6_data", {24'd0, uart_tx_data}, 32'h21);
    uart_rd_en = 1'b1;
    #1;
    chk("t6_send_rd_en", {28'd0, req_rd_en}, 0);
    tick();
    uart_rd_en = 1'b0;
    chk("t6_send_empty", {31'd0, uart_empty}, 1);
    chk("t6_send_busy", {31'd0, busy}, 1);
    chk("t6_send_data", {24'd0, uart_tx_data}, 32'h21);
    uart_tx_done = 1'b1;
    tick();
    uart_tx_done = 1'b0;
    serve(1, 8'h22, 0);
    chk("t6_end_busy", {31'd0, busy}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
